// File: rtl/way3_voter_pkg.sv
// Shared types for the way3 TMR voter/monitor.
//   NUM_REPLICAS   : number of redundant replicas (fixed at 3)
//   LANE_W         : lane width carried in lane_vote_t; the voter's LANE_WIDTH
//                    parameter must match it
//   replica_t      : replica index
//   replica_mask_t : one bit per replica (dissent / healthy / failed masks)
//   lane_vote_t    : result of one lane vote
package way3_voter_pkg;
  localparam int NUM_REPLICAS = 3;
  localparam int LANE_W       = 8;

  typedef logic [1:0]              replica_t;
  typedef logic [NUM_REPLICAS-1:0] replica_mask_t;

  typedef struct packed {
    logic [LANE_W-1:0] value;
    logic              err1;
    logic              err2;
    replica_mask_t     dissent;
  } lane_vote_t;
endpackage

// File: rtl/way3_lane_vote.sv
// Combinational majority vote of one lane across three replicas.
// Ports:
//   in0/in1/in2 : lane slice of each replica
//   healthy     : replicas allowed to vote (only when VOTER_MASK_EN is defined)
//   res         : voted value, err1 (any disagreement), err2 (no majority),
//                 dissent (sole dissenting replica, one-hot)
// Macro VOTER_MASK_EN: excludes unhealthy replicas from the vote.
module way3_lane_vote
  import way3_voter_pkg::*;
#(
  parameter int LANE_WIDTH = LANE_W
) (
  input  logic [LANE_WIDTH-1:0] in0,
  input  logic [LANE_WIDTH-1:0] in1,
  input  logic [LANE_WIDTH-1:0] in2,
`ifdef VOTER_MASK_EN
  input  replica_mask_t         healthy,
`endif
  output lane_vote_t            res
);
  logic       eq01, eq02, eq12;
  lane_vote_t full;

  assign eq01 = (in0 == in1);
  assign eq02 = (in0 == in2);
  assign eq12 = (in1 == in2);

  // Priority order matters: when no pair agrees, in0 is passed through.
  always_comb begin
    full      = '0;
    full.err1 = !(eq01 && eq12);
    if (eq01) begin
      full.value      = in0;
      full.dissent[2] = !eq02;
    end else if (eq02) begin
      full.value      = in0;
      full.dissent[1] = 1'b1;
    end else if (eq12) begin
      full.value      = in1;
      full.dissent[0] = 1'b1;
    end else begin
      full.value = in0;
      full.err2  = 1'b1;
    end
  end

`ifdef VOTER_MASK_EN
  // Two-replica compare: a mismatch cannot be resolved, so it is err2 too.
  function automatic lane_vote_t pair_vote(input logic [LANE_WIDTH-1:0] lo,
                                           input logic [LANE_WIDTH-1:0] hi);
    lane_vote_t r;
    r       = '0;
    r.value = lo;
    r.err1  = (lo != hi);
    r.err2  = (lo != hi);
    return r;
  endfunction

  always_comb begin
    res = full;
    case (healthy)
      3'b111: res = full;
      3'b110: res = pair_vote(in1, in2);
      3'b101: res = pair_vote(in0, in2);
      3'b011: res = pair_vote(in0, in1);
      default: begin
        // Fewer than two voters: pass lowest healthy replica, always flag.
        res       = '0;
        res.value = healthy[0] ? in0 : healthy[1] ? in1 : healthy[2] ? in2 : in0;
        res.err1  = 1'b1;
        res.err2  = 1'b1;
      end
    endcase
  end
`else
  assign res = full;
`endif
endmodule

// File: rtl/way3_voter_mon.sv
// Registered multi-lane TMR voter with fault monitoring.
// Ports:
//   clk_i, rst_i (sync, active high)
//   valid_i, in0_i/in1_i/in2_i : replica samples
//   clr_i          : clears event counters, persistence state, fail flags
//   out_o, valid_o : voted output, 1-cycle latency
//   error1_o       : some lane disagreed; error2_o : some lane had no majority
//   dissent_o      : replica r was sole dissenter in some lane
//   err1_cnt_o, err2_cnt_o : saturating event counters
//   replica_fail_o : sticky, set after PERSIST_THR consecutive dissents
// Macro VOTER_MASK_EN: failed replicas are excluded from voting.
module way3_voter_mon
  import way3_voter_pkg::*;
#(
  parameter int LANE_WIDTH  = 8,
  parameter int NUM_LANES   = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int PERSIST_THR = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            valid_i,
  input  logic [LANE_WIDTH*NUM_LANES-1:0] in0_i,
  input  logic [LANE_WIDTH*NUM_LANES-1:0] in1_i,
  input  logic [LANE_WIDTH*NUM_LANES-1:0] in2_i,
  input  logic                            clr_i,
  output logic [LANE_WIDTH*NUM_LANES-1:0] out_o,
  output logic                            valid_o,
  output logic                            error1_o,
  output logic                            error2_o,
  output logic [2:0]                      dissent_o,
  output logic [CNT_WIDTH-1:0]            err1_cnt_o,
  output logic [CNT_WIDTH-1:0]            err2_cnt_o,
  output logic [2:0]                      replica_fail_o
);
  localparam int W  = LANE_WIDTH*NUM_LANES;
  localparam int PW = $clog2(PERSIST_THR+1);
  localparam logic [PW-1:0] THR = PW'(PERSIST_THR);

  lane_vote_t    lv [NUM_LANES];
  logic [W-1:0]  vote;
  logic          e1, e2;
  replica_mask_t dis;
  logic [PW-1:0] pcnt     [NUM_REPLICAS];
  logic [PW-1:0] pcnt_nxt [NUM_REPLICAS];
  replica_mask_t fail_nxt;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    way3_lane_vote #(.LANE_WIDTH(LANE_WIDTH)) u_lane (
      .in0     (in0_i[i*LANE_WIDTH +: LANE_WIDTH]),
      .in1     (in1_i[i*LANE_WIDTH +: LANE_WIDTH]),
      .in2     (in2_i[i*LANE_WIDTH +: LANE_WIDTH]),
`ifdef VOTER_MASK_EN
      .healthy (~replica_fail_o),
`endif
      .res     (lv[i])
    );
  end

  always_comb begin
    vote = '0;
    e1   = 1'b0;
    e2   = 1'b0;
    dis  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      vote[i*LANE_WIDTH +: LANE_WIDTH] = lv[i].value;
      e1  = e1 | lv[i].err1;
      e2  = e2 | lv[i].err2;
      dis = dis | lv[i].dissent;
    end
  end

  // Consecutive-dissent tracking; a valid sample without dissent from r
  // (including a pure no-majority sample) restarts r's count.
  always_comb begin
    fail_nxt = replica_fail_o;
    for (int r = 0; r < NUM_REPLICAS; r++) begin
      pcnt_nxt[r] = pcnt[r];
      if (valid_i) begin
`ifdef VOTER_MASK_EN
        if (replica_fail_o[r]) begin
          pcnt_nxt[r] = pcnt[r];  // excluded replica: frozen
        end else
`endif
        if (dis[r]) begin
          pcnt_nxt[r] = (pcnt[r] == THR) ? THR : pcnt[r] + 1'b1;
          if (pcnt_nxt[r] == THR) fail_nxt[r] = 1'b1;
        end else begin
          pcnt_nxt[r] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_o          <= '0;
      valid_o        <= 1'b0;
      error1_o       <= 1'b0;
      error2_o       <= 1'b0;
      dissent_o      <= '0;
      err1_cnt_o     <= '0;
      err2_cnt_o     <= '0;
      replica_fail_o <= '0;
      for (int r = 0; r < NUM_REPLICAS; r++) pcnt[r] <= '0;
    end else begin
      valid_o   <= valid_i;
      error1_o  <= valid_i & e1;
      error2_o  <= valid_i & e2;
      dissent_o <= valid_i ? dis : 3'b000;
      if (valid_i) out_o <= vote;
      // Clear beats any same-cycle increment or fail set.
      if (clr_i) begin
        err1_cnt_o     <= '0;
        err2_cnt_o     <= '0;
        replica_fail_o <= '0;
        for (int r = 0; r < NUM_REPLICAS; r++) pcnt[r] <= '0;
      end else if (valid_i) begin
        if (e1 && (err1_cnt_o != '1)) err1_cnt_o <= err1_cnt_o + 1'b1;
        if (e2 && (err2_cnt_o != '1)) err2_cnt_o <= err2_cnt_o + 1'b1;
        replica_fail_o <= fail_nxt;
        for (int r = 0; r < NUM_REPLICAS; r++) pcnt[r] <= pcnt_nxt[r];
      end
    end
  end
endmodule

// File: tb/tb_way3_voter_mon.sv
module tb_way3_voter_mon;
  logic        clk = 1'b0;
  logic        rst, valid, clr;
  logic [31:0] in0, in1, in2;
  logic [31:0] out;
  logic        valid_o, e1_o, e2_o;
  logic [2:0]  dis_o, fail_o;
  logic [15:0] c1_o, c2_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        v;
    logic [31:0] out;
    logic        e1, e2;
    logic [2:0]  dis;
    logic [15:0] c1, c2;
    logic [2:0]  fail;
  } exp_t;
  exp_t sb[$];

  // reference state
  logic [31:0] m_out;
  logic [15:0] m_c1, m_c2;
  int          m_p[3];
  logic [2:0]  m_fail;

  always #5 clk = ~clk;

  way3_voter_mon dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid),
    .in0_i(in0), .in1_i(in1), .in2_i(in2), .clr_i(clr),
    .out_o(out), .valid_o(valid_o), .error1_o(e1_o), .error2_o(e2_o),
    .dissent_o(dis_o), .err1_cnt_o(c1_o), .err2_cnt_o(c2_o),
    .replica_fail_o(fail_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void ref_vote(input logic [31:0] a, b, c, input logic [2:0] h,
                                   output logic [31:0] v, output logic e1, e2,
                                   output logic [2:0] d);
    logic [7:0] x[3];
    int hc, lo, hi;
    v = '0; e1 = 0; e2 = 0; d = '0;
    hc = int'(h[0]) + int'(h[1]) + int'(h[2]);
    for (int L = 0; L < 4; L++) begin
      x[0] = a[8*L +: 8]; x[1] = b[8*L +: 8]; x[2] = c[8*L +: 8];
      if (hc == 3) begin
        if (x[0] == x[1] && x[1] == x[2]) v[8*L +: 8] = x[0];
        else if (x[0] == x[1] || x[0] == x[2]) begin
          v[8*L +: 8] = x[0]; e1 = 1;
          if (x[0] == x[1]) d[2] = 1; else d[1] = 1;
        end else if (x[1] == x[2]) begin
          v[8*L +: 8] = x[1]; e1 = 1; d[0] = 1;
        end else begin
          v[8*L +: 8] = x[0]; e1 = 1; e2 = 1;
        end
      end else if (hc == 2) begin
        lo = h[0] ? 0 : 1;
        hi = h[2] ? 2 : 1;
        v[8*L +: 8] = x[lo];
        if (x[lo] != x[hi]) begin e1 = 1; e2 = 1; end
      end else begin
        v[8*L +: 8] = h[0] ? x[0] : h[1] ? x[1] : h[2] ? x[2] : x[0];
        e1 = 1; e2 = 1;
      end
    end
  endfunction

  task automatic step(input bit r, input bit v, input logic [31:0] a, b, c,
                      input bit cl, input bit check);
    exp_t e;
    logic [31:0] vv;
    logic ve1, ve2;
    logic [2:0] vd, h;
    @(negedge clk);
    rst = r; valid = v; in0 = a; in1 = b; in2 = c; clr = cl;
`ifdef VOTER_MASK_EN
    h = ~m_fail;
`else
    h = 3'b111;
`endif
    ref_vote(a, b, c, h, vv, ve1, ve2, vd);
    if (r) begin
      m_out = '0; m_c1 = '0; m_c2 = '0; m_fail = '0;
      for (int i = 0; i < 3; i++) m_p[i] = 0;
      e = '0;
    end else begin
      if (v) m_out = vv;
      if (cl) begin
        m_c1 = '0; m_c2 = '0; m_fail = '0;
        for (int i = 0; i < 3; i++) m_p[i] = 0;
      end else if (v) begin
        if (ve1 && m_c1 != 16'hFFFF) m_c1++;
        if (ve2 && m_c2 != 16'hFFFF) m_c2++;
        for (int i = 0; i < 3; i++) begin
          if (!h[i]) continue;
          if (vd[i]) begin
            if (m_p[i] < 4) m_p[i]++;
            if (m_p[i] == 4) m_fail[i] = 1'b1;
          end else m_p[i] = 0;
        end
      end
      e.v = v; e.out = m_out;
      e.e1 = v & ve1; e.e2 = v & ve2; e.dis = v ? vd : 3'b000;
      e.c1 = m_c1; e.c2 = m_c2; e.fail = m_fail;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    if (check) begin
      chk("valid", {31'b0, valid_o}, {31'b0, e.v});
      chk("out", out, e.out);
      chk("err1", {31'b0, e1_o}, {31'b0, e.e1});
      chk("err2", {31'b0, e2_o}, {31'b0, e.e2});
      chk("dissent", {29'b0, dis_o}, {29'b0, e.dis});
      chk("cnt1", {16'b0, c1_o}, {16'b0, e.c1});
      chk("cnt2", {16'b0, c2_o}, {16'b0, e.c2});
      chk("fail", {29'b0, fail_o}, {29'b0, e.fail});
    end
  endtask

  initial begin
    rst = 1; valid = 0; clr = 0; in0 = '0; in1 = '0; in2 = '0;
    m_out = '0; m_c1 = '0; m_c2 = '0; m_fail = '0;
    for (int i = 0; i < 3; i++) m_p[i] = 0;

    // reset state
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 1, 32'h1, 32'h2, 32'h3, 0, 1);
    chk("rst_out", out, 32'h0);
    chk("rst_valid", {31'b0, valid_o}, 32'h0);

    // all agree
    repeat (3) step(0, 1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 1);
    chk("agree_out", out, 32'hA5A5A5A5);
    chk("agree_cnt1", {16'b0, c1_o}, 32'h0);

    // replica 2 dissents in lane 0
    step(0, 1, 32'h0, 32'h0, 32'h000000FF, 0, 1);
    chk("d2_out", out, 32'h0);
    chk("d2_dis", {29'b0, dis_o}, 32'h4);
    chk("d2_cnt1", {16'b0, c1_o}, 32'h1);

    // no majority in lane 0
    step(0, 1, 32'h0, 32'h0, 32'h0, 1, 1);
    step(0, 1, 32'hABCDEF11, 32'hABCDEF22, 32'hABCDEF33, 0, 1);
    chk("nm_out", out, 32'hABCDEF11);
    chk("nm_err2", {31'b0, e2_o}, 32'h1);
    chk("nm_dis", {29'b0, dis_o}, 32'h0);
    chk("nm_cnt", {c1_o, c2_o}, 32'h00010001);

    // in1 dissents 4 times, idle cycle between 2nd and 3rd
    step(0, 1, 0, 0, 0, 1, 1);
    step(0, 1, 32'h0, 32'h0000FF00, 32'h0, 0, 1);
    step(0, 1, 32'h0, 32'h0000FF00, 32'h0, 0, 1);
    step(0, 0, 32'h0, 32'h0000FF00, 32'h0, 0, 1);
    step(0, 1, 32'h0, 32'h0000FF00, 32'h0, 0, 1);
    chk("p3_fail", {29'b0, fail_o}, 32'h0);
    step(0, 1, 32'h0, 32'h0000FF00, 32'h0, 0, 1);
    chk("p4_fail", {29'b0, fail_o}, 32'h2);

    // clean sample breaks the run
    step(0, 1, 0, 0, 0, 1, 1);
    repeat (3) step(0, 1, 32'h0, 32'h0000FF00, 32'h0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    step(0, 1, 32'h0, 32'h0000FF00, 32'h0, 0, 1);
    chk("brk_fail", {29'b0, fail_o}, 32'h0);

    // saturate both counters with no-majority samples
    step(0, 1, 0, 0, 0, 1, 1);
    repeat (65535) step(0, 1, 32'h1, 32'h2, 32'h3, 0, 0);
    step(0, 1, 32'h1, 32'h2, 32'h3, 0, 1);
    chk("sat_cnt", {c1_o, c2_o}, 32'hFFFFFFFF);
    // clear with simultaneous erroneous sample
    step(0, 1, 32'h1, 32'h2, 32'h3, 1, 1);
    chk("clr_cnt", {c1_o, c2_o}, 32'h0);
    chk("clr_err1", {31'b0, e1_o}, 32'h1);

    // idle holds out; reset mid-stream discards pending sample
    step(0, 0, 32'h55, 32'h66, 32'h77, 0, 1);
    chk("idle_out", out, 32'h1);
    step(0, 1, 32'h0000FF00, 32'h0, 32'h0, 0, 1);
    step(1, 1, 32'h0000FF00, 32'h0, 32'h0, 0, 1);
    chk("mid_rst_valid", {31'b0, valid_o}, 32'h0);
    step(0, 1, 32'h12, 32'h12, 32'h12, 0, 1);

`ifdef VOTER_MASK_EN
    // fail replica 0, then vote among replicas 1/2
    repeat (4) step(0, 1, 32'h000000AA, 32'h0, 32'h0, 0, 1);
    chk("m_fail", {29'b0, fail_o}, 32'h1);
    step(0, 1, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 0, 1);
    chk("m_out", out, 32'h12345678);
    chk("m_err1", {31'b0, e1_o}, 32'h0);
    step(0, 1, 32'hDEADBEEF, 32'h11111111, 32'h22222222, 0, 1);
    chk("m_out2", out, 32'h11111111);
    chk("m_err2", {31'b0, e2_o}, 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/way3_voter_mon.md
Name: way3_voter_mon

Overview:
- Registered, multi-lane triple-modular-redundancy voter with fault monitoring, used behind replicated SafeSU datapaths.
- Splits each replica input into NUM_LANES independent lanes and majority-votes each lane.
- Counts recoverable and unrecoverable events in saturating counters.
- Identifies the dissenting replica and flags a replica as failed after PERSIST_THR consecutive dissents.

Parameters:
- LANE_WIDTH, 8: bits per voted lane.
- NUM_LANES, 4: lanes per replica; total width W = LANE_WIDTH*NUM_LANES.
- CNT_WIDTH, 16: width of the event counters.
- PERSIST_THR, 4: consecutive valid dissenting samples before a replica is declared failed; legal range ≥1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  replica samples valid this cycle
- in0_i / in1_i / in2_i  in  W  replica inputs
- clr_i  in  1  clears counters, sticky flags and persistence state
- out_o  out  W  voted output
- valid_o  out  1  out_o/error flags valid
- error1_o  out  1  at least one lane disagreed (includes error2 cases)
- error2_o  out  1  at least one lane has no majority
- dissent_o  out  3  one-hot-per-replica: replica r was the sole dissenter in some lane
- err1_cnt_o / err2_cnt_o  out  CNT_WIDTH  saturating event counts
- replica_fail_o  out  3  sticky failed-replica flags

Behaviour:
- Interface: one clock, clk_i; rst_i is synchronous and active-high. Reset drives every output and internal counter to 0.
- Per-lane vote (combinational), evaluated in order:
  - in0==in1: out=in0; dissenter = replica 2 if in2 differs.
  - else in0==in2: out=in0; dissenter = replica 1.
  - else in1==in2: out=in1; dissenter = replica 0.
  - else: out=in0; lane error2; no dissenter attributed.
  - Lane error1 = any mismatch among the three.
- Aggregation: error1_o = OR of lane error1; error2_o = OR of lane error2; dissent_o[r] = OR over lanes of "r is dissenter".
- Latency: exactly 1 cycle. A sample with valid_i=1 at cycle t appears on out_o/valid_o/error*/dissent_o at t+1.
- valid_i=0: at the next edge valid_o=0, error1_o=error2_o=0, dissent_o=0; out_o holds its last value; counters and persistence unchanged.
- Counters (per valid sample, at most +1):
  - err1_cnt increments when that sample's error1 is 1.
  - err2_cnt increments when error2 is 1.
  - Both saturate at 2^CNT_WIDTH-1 with no wrap.
- Persistence: per replica, a consecutive-dissent counter of width $clog2(PERSIST_THR+1).
  - Each valid sample: +1 if r dissents, else cleared to 0.
  - Invalid cycles leave it unchanged.
  - An error2-only sample clears all three.
  - When the count reaches PERSIST_THR, replica_fail_o[r] sets in the same update, visible with that sample's registered outputs. It stays set until clr_i or reset; the counter saturates at PERSIST_THR.
- clr_i: next edge zeroes counters, persistence counters and replica_fail_o.
  - clr_i with a simultaneous valid erroneous sample: clear wins, that increment/fail-set is dropped.
  - out_o/valid_o/error1_o/error2_o/dissent_o still register the sample normally.
- Reset mid-stream: the pending sample is discarded and valid_o=0 the next cycle.

Optional Feature:
- Macro: VOTER_MASK_EN.
- Defined: replicas with replica_fail_o set are excluded from voting.
  - One failed: the two healthy replicas compare per lane. Equal gives out=that value, no error. Different gives out = lower-index healthy replica, error1 and error2 for that lane, no dissent attribution. The failed replica's persistence counter is frozen.
  - Two or three failed: out = lowest-index healthy replica (in0 if none); error1_o=error2_o=1 on every valid sample.
- Undefined: replica_fail_o is status only; voting is always full 3-way. No masking logic is synthesised.

Decomposition:
- Package way3_voter_pkg holds:
  - NUM_REPLICAS=3 constant.
  - replica_t (2-bit index) and replica_mask_t (3-bit) typedefs.
  - The lane-vote result struct {value, err1, err2, dissent[2:0]}.
- Sub-module way3_lane_vote: combinational single-lane vote with optional healthy-mask input, instantiated NUM_LANES times via generate. Registers, counters and persistence live in the top.

Test Plan:
- All replicas 0xA5A5A5A5, valid_i=1 for 3 cycles -> out_o=0xA5A5A5A5 one cycle later, error1_o=error2_o=0, counters remain 0.
- in2_i=0x000000FF, others 0 for one valid cycle -> out_o=0, error1_o=1, error2_o=0, dissent_o=3'b100, err1_cnt_o=1.
- Lane 0 bytes 0x11/0x22/0x33, other lanes equal -> out_o lane0=0x11, error2_o=1, dissent_o=0, err1_cnt=err2_cnt=1, persistence counters cleared.
- in1 dissents for 4 consecutive valid samples, with an idle cycle between samples 2 and 3 -> replica_fail_o=3'b010 with the 4th sample's output.
  - Variant: one clean sample after the 3rd dissent -> no fail.
- Counters preloaded to max via forced 2^16-1 errors -> counters stay 16'hFFFF.
  - clr_i asserted with an erroneous sample -> counters 0 next cycle, valid_o=1, error1_o=1.
- VOTER_MASK_EN, replica_fail_o=3'b001, in0=0xDEADBEEF, in1=in2=0x12345678 -> out_o=0x12345678, no error.
  - Then in1≠in2 -> out=in1, error2_o=1.
